// File: rtl/proj_exhaustive_driver.sv
// rtl/proj_exhaustive_driver.sv - exhaustive stimulus driver and y0 signature capture for a projection netlist
module proj_exhaustive_driver #(
    parameter int              N_IN         = 24,
    parameter logic [N_IN-1:0] SUPPORT_MASK = 24'h00000E,
    parameter logic [N_IN-1:0] FILL_VALUE   = 24'h000000,
    parameter int              CNT_W        = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  x_out,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vector_index,
    output logic [CNT_W-1:0] ones_count,
    output logic [15:0]      signature
);

    function automatic int popcount(input logic [N_IN-1:0] m);
        int n;
        n = 0;
        for (int i = 0; i < N_IN; i++) begin
            if (m[i]) n++;
        end
        return n;
    endfunction

    localparam int K = popcount(SUPPORT_MASK);

    // More than 16 support inputs would overflow the counter and make the run impractically long.
    if (K > 16) begin : g_k_too_large
        $error("proj_exhaustive_driver: SUPPORT_MASK selects more than 16 inputs");
    end

    localparam logic [CNT_W-1:0] L_LAST = CNT_W'((64'd1 << K) - 64'd1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Scatter counter bit j onto the j-th lowest set bit of the support mask.
    function automatic logic [N_IN-1:0] pdep(input logic [CNT_W-1:0] cnt);
        logic [N_IN-1:0]  x;
        logic [CNT_W-1:0] shifted;
        int               j;
        x = FILL_VALUE;
        j = 0;
        for (int i = 0; i < N_IN; i++) begin
            if (SUPPORT_MASK[i]) begin
                shifted = cnt >> j;
                x[i]    = shifted[0];
                j++;
            end
        end
        return x;
    endfunction

    logic [0:0]       r_state;
    logic [N_IN-1:0]  r_x_out;
    logic             r_done;
    logic [CNT_W-1:0] r_vector_index;
    logic [CNT_W-1:0] r_ones_count;
    logic [15:0]      r_signature;

    logic [CNT_W-1:0] w_next_index;
    logic [N_IN-1:0]  w_next_pattern;
    logic [N_IN-1:0]  w_first_pattern;
    logic             w_last;
    logic [15:0]      w_next_signature;

    // Next vector, first vector, end-of-run detect and MISR step.
    always_comb begin
        w_next_index     = r_vector_index + CNT_W'(1);
        w_next_pattern   = pdep(w_next_index);
        w_first_pattern  = pdep('0);
        w_last           = (r_vector_index == L_LAST);
        w_next_signature = {r_signature[14:0], y_in} ^ (r_signature[15] ? 16'h1021 : 16'h0000);
    end

    // Run control: accept start in IDLE, step through every vector in RUN, pulse done at the end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_x_out        <= FILL_VALUE;
            r_done         <= 1'b0;
            r_vector_index <= '0;
            r_ones_count   <= '0;
            r_signature    <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_x_out <= FILL_VALUE;
                    if (start) begin
                        r_state        <= S_RUN;
                        r_x_out        <= w_first_pattern;
                        r_vector_index <= '0;
                        r_ones_count   <= '0;
                        r_signature    <= 16'h0000;
                    end
                end
                default: begin
                    // y_in reflects the vector currently on x_out.
                    r_ones_count <= r_ones_count + CNT_W'(y_in);
                    r_signature  <= w_next_signature;
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_x_out <= FILL_VALUE;
                    end else begin
                        r_vector_index <= w_next_index;
                        r_x_out        <= w_next_pattern;
                    end
                end
            endcase
        end
    end

    assign x_out        = r_x_out;
    assign busy         = (r_state == S_RUN);
    assign done         = r_done;
    assign vector_index = r_vector_index;
    assign ones_count   = r_ones_count;
    assign signature    = r_signature;

endmodule

// File: tb/tb_proj_exhaustive_driver.sv
// tb/tb_proj_exhaustive_driver.sv - randomized self-checking bench for proj_exhaustive_driver
module tb_proj_exhaustive_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_d;
    logic        use_tt;
    logic [7:0]  tt;

    logic [23:0] x_out;
    logic        y_in;
    logic        busy;
    logic        done;
    logic [16:0] vector_index;
    logic [16:0] ones_count;
    logic [15:0] signature;

    logic [23:0] x_out_d;
    logic        y_in_d;
    logic        busy_d;
    logic        done_d;
    logic [16:0] vector_index_d;
    logic [16:0] ones_count_d;
    logic [15:0] signature_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Projection netlist stand-in: fixed function or a random 3-input truth table on x3:x1.
    assign y_in   = use_tt ? tt[x_out[3:1]] : ~(x_out[2] ? x_out[1] : x_out[3]);
    assign y_in_d = 1'b1;

    proj_exhaustive_driver u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .x_out        (x_out),
        .y_in         (y_in),
        .busy         (busy),
        .done         (done),
        .vector_index (vector_index),
        .ones_count   (ones_count),
        .signature    (signature)
    );

    proj_exhaustive_driver #(
        .SUPPORT_MASK (24'h000000),
        .FILL_VALUE   (24'h000004)
    ) u_deg (
        .clk          (clk),
        .rst          (rst),
        .start        (start_d),
        .x_out        (x_out_d),
        .y_in         (y_in_d),
        .busy         (busy_d),
        .done         (done_d),
        .vector_index (vector_index_d),
        .ones_count   (ones_count_d),
        .signature    (signature_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Place bit j of v onto the j-th lowest set bit of mask, peeling mask bits from the bottom.
    function automatic logic [23:0] deposit(input logic [23:0] mask, input logic [23:0] fill, input int v);
        logic [23:0] m;
        logic [23:0] x;
        logic [23:0] low;
        int          j;
        m = mask;
        x = fill;
        j = 0;
        while (m != 24'd0) begin
            low = m & (~m + 24'd1);
            if (((v >> j) & 1) != 0) x = x | low;
            else                     x = x & ~low;
            m = m & ~low;
            j++;
        end
        return x;
    endfunction

    function automatic logic ref_y(input logic [23:0] x);
        if (use_tt) return tt[{x[3], x[2], x[1]}];
        return (x[2] ? x[1] : x[3]) ? 1'b0 : 1'b1;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on the falling edge just after start was sampled; walks the 8-vector run.
    task automatic run_check(input string name, input int restart_at, input bit chain);
        int          exp_ones;
        logic [15:0] exp_sig;
        logic [23:0] exp_x;
        logic        y;
        exp_ones = 0;
        exp_sig  = 16'h0000;
        for (int v = 0; v < 8; v++) begin
            exp_x = deposit(24'h00000E, 24'h000000, v);
            check({name, ".busy"}, 32'(busy), 32'd1);
            check({name, ".x_out"}, 32'(x_out), 32'(exp_x));
            check({name, ".index"}, 32'(vector_index), 32'(v));
            check({name, ".done_early"}, 32'(done), 32'd0);
            if (v == 0) begin
                check({name, ".ones_clr"}, 32'(ones_count), 32'd0);
                check({name, ".sig_clr"}, 32'(signature), 32'd0);
            end
            y        = ref_y(exp_x);
            exp_ones = exp_ones + int'(y);
            exp_sig  = {exp_sig[14:0], y} ^ (exp_sig[15] ? 16'h1021 : 16'h0000);
            start    = (v == restart_at);
            @(negedge clk);
        end
        start = chain;
        check({name, ".done"}, 32'(done), 32'd1);
        check({name, ".busy_end"}, 32'(busy), 32'd0);
        check({name, ".x_idle"}, 32'(x_out), 32'd0);
        check({name, ".index_hold"}, 32'(vector_index), 32'd7);
        check({name, ".ones"}, 32'(ones_count), 32'(exp_ones));
        check({name, ".sig"}, 32'(signature), 32'(exp_sig));
        @(negedge clk);
        start = 1'b0;
        if (!chain) begin
            check({name, ".done_once"}, 32'(done), 32'd0);
            check({name, ".ones_hold"}, 32'(ones_count), 32'(exp_ones));
            check({name, ".sig_hold"}, 32'(signature), 32'(exp_sig));
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        start_d = 1'b0;
        use_tt  = 1'b0;
        tt      = 8'h00;

        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 1) rst = 1'b0;
            check("reset.x_out", 32'(x_out), 32'd0);
            check("reset.busy", 32'(busy), 32'd0);
            check("reset.done", 32'(done), 32'd0);
            check("reset.ones", 32'(ones_count), 32'd0);
            check("reset.sig", 32'(signature), 32'd0);
            check("reset.x_deg", 32'(x_out_d), 32'h4);
        end

        pulse_start();
        run_check("dflt", -1, 1'b0);
        check("dflt.ones_const", 32'(ones_count), 32'd4);
        check("dflt.sig_const", 32'(signature), 32'h00E2);

        pulse_start();
        run_check("busy_start", 3, 1'b0);
        check("busy_start.sig_const", 32'(signature), 32'h00E2);

        pulse_start();
        repeat (5) @(negedge clk);
        check("midrst.index", 32'(vector_index), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.x_out", 32'(x_out), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.ones", 32'(ones_count), 32'd0);
        check("midrst.sig", 32'(signature), 32'd0);
        for (int c = 0; c < 4; c++) begin
            check("midrst.no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        pulse_start();
        run_check("after_rst", -1, 1'b0);
        check("after_rst.ones_const", 32'(ones_count), 32'd4);
        check("after_rst.sig_const", 32'(signature), 32'h00E2);

        pulse_start();
        run_check("b2b_a", -1, 1'b1);
        run_check("b2b_b", -1, 1'b0);
        check("b2b_b.sig_const", 32'(signature), 32'h00E2);

        use_tt = 1'b1;
        for (int r = 0; r < 6; r++) begin
            tt = 8'($urandom);
            pulse_start();
            run_check("rand", -1, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        use_tt = 1'b0;

        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        check("deg.busy", 32'(busy_d), 32'd1);
        check("deg.x_out", 32'(x_out_d), 32'h4);
        check("deg.index", 32'(vector_index_d), 32'd0);
        @(negedge clk);
        check("deg.busy_end", 32'(busy_d), 32'd0);
        check("deg.done", 32'(done_d), 32'd1);
        check("deg.ones", 32'(ones_count_d), 32'd1);
        check("deg.sig", 32'(signature_d), 32'h0001);
        check("deg.x_idle", 32'(x_out_d), 32'h4);
        @(negedge clk);
        check("deg.done_once", 32'(done_d), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
